// File: rtl/sram_port0_ctrl.sv
// Port-0 front-end for the sram macro: registered pin drive,
// two-stage tag pipeline and an in-order response FIFO.
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [NUM_WMASKS-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 2;
  localparam logic [PW:0]   FULL = RSP_DEPTH[PW:0];
  localparam logic [CW-1:0] LIM  = RSP_DEPTH[CW-1:0];

  logic                  w_acc;
  logic                  w_err;
  logic                  w_nop;
  logic                  w_access;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [CW-1:0]         w_out;
  logic                  w_unused;

  logic                  r_s0_valid;
  logic                  r_s0_we;
  logic                  r_s0_err;
  logic                  r_csb;
  logic                  r_web;
  logic [NUM_WMASKS-1:0] r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic                  r_s1_valid;
  logic                  r_s1_we;
  logic                  r_s1_err;

  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
  logic                  r_fifo_err  [RSP_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_cnt;

  assign w_unused = ^req_addr_i[1:0];

  // Credit count uses only registered state, never rsp_ready_i.
  assign w_out = CW'(r_s0_valid) + CW'(r_s1_valid) + CW'(r_cnt);
  assign req_ready_o = (w_out < LIM);

  assign w_acc    = req_valid_i && req_ready_o;
  assign w_err    = |req_addr_i[31:ADDR_WIDTH+2];
  assign w_nop    = req_we_i && (req_be_i == '0);
  assign w_access = w_acc && !w_err && !w_nop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s0_valid <= 1'b0;
      r_s0_we    <= 1'b0;
      r_s0_err   <= 1'b0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_wmask    <= '0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_s0_valid <= w_acc;
      r_s0_we    <= req_we_i;
      r_s0_err   <= w_err;
      r_csb      <= !w_access;
      r_web      <= !(w_access && req_we_i);
      r_wmask    <= (w_access && req_we_i) ? req_be_i : '0;
      if (w_access) begin
        r_addr <= req_addr_i[ADDR_WIDTH+1:2];
        r_din  <= req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_valid <= r_s0_valid;
      r_s1_we    <= r_s0_we;
      r_s1_err   <= r_s0_err;
    end
  end

  assign w_push = r_s1_valid;
  assign w_pop  = rsp_valid_o && rsp_ready_i;
  assign w_push_data = (!r_s1_we && !r_s1_err) ? sram_dout0_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_push_data;
        r_fifo_err[r_wptr]  <= r_s1_err;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_push && (r_cnt == FULL)));
    end
  end
`endif

  assign rsp_valid_o = (r_cnt != '0);
  assign rsp_rdata_o = rsp_valid_o ? r_fifo_data[r_rptr] : '0;
  assign rsp_err_o   = rsp_valid_o && r_fifo_err[r_rptr];

  assign sram_csb0_o   = r_csb;
  assign sram_web0_o   = r_web;
  assign sram_wmask0_o = r_wmask;
  assign sram_addr0_o  = r_addr;
  assign sram_din0_o   = r_din;

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: SRAM macro model, transaction-level
// reference model with per-cycle compare, and directed scenarios.
module tb_sram_port0_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        sram_csb0_o;
  logic        sram_web0_o;
  logic [3:0]  sram_wmask0_o;
  logic [9:0]  sram_addr0_o;
  logic [31:0] sram_din0_o;
  logic [31:0] sram_dout0_i = '0;

  always #5 clk = ~clk;

  sram_port0_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_be_i      (req_be_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .sram_csb0_o   (sram_csb0_o),
    .sram_web0_o   (sram_web0_o),
    .sram_wmask0_o (sram_wmask0_o),
    .sram_addr0_o  (sram_addr0_o),
    .sram_din0_o   (sram_din0_o),
    .sram_dout0_i  (sram_dout0_i)
  );

  // SRAM macro: latch pins at posedge, write/read at negedge
  logic [31:0] sram_mem [0:1023];
  logic        l_csb = 1'b1;
  logic        l_web = 1'b1;
  logic [3:0]  l_mask = '0;
  logic [9:0]  l_addr = '0;
  logic [31:0] l_din = '0;
  logic [31:0] sw;

  always @(posedge clk) begin
    l_csb  <= sram_csb0_o;
    l_web  <= sram_web0_o;
    l_mask <= sram_wmask0_o;
    l_addr <= sram_addr0_o;
    l_din  <= sram_din0_o;
  end

  always @(negedge clk) begin
    if (!l_csb) begin
      if (!l_web) begin
        sw = sram_mem[l_addr];
        for (int b = 0; b < 4; b++)
          if (l_mask[b]) sw[8*b +: 8] = l_din[8*b +: 8];
        sram_mem[l_addr] <= sw;
      end else begin
        sram_dout0_i <= sram_mem[l_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } ex_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    int          cyc;
  } got_t;

  ex_t         q[$];
  got_t        got[$];
  logic [31:0] mmem [0:1023];
  int          n = 0;
  int          tests = 0;
  int          fails = 0;
  int          waits = 0;
  logic        pa_v = 1'b0;
  logic        pa_we;
  logic [3:0]  pa_mask;
  logic [9:0]  pa_addr;
  logic [31:0] pa_din;
  logic [9:0]  last_addr = '0;
  logic [31:0] last_din = '0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, n);
    end
  endfunction

  // Reference model: one request = one queue entry, data resolved at accept
  always @(negedge clk) begin
    logic        ev;
    logic        mrdy;
    logic        e;
    logic        nop;
    logic [9:0]  wa;
    logic [31:0] d;
    logic [31:0] m;
    if (!rst_ni) begin
      q.delete();
      pa_v = 1'b0;
      last_addr = '0;
      last_din = '0;
    end else begin
      ev   = (q.size() > 0) && (q[0].acc + 2 <= n);
      mrdy = (q.size() < 4);
      chk("req_ready", req_ready_o, mrdy);
      chk("rsp_valid", rsp_valid_o, ev);
      if (ev) begin
        chk("rsp_rdata", rsp_rdata_o, q[0].data);
        chk("rsp_err", rsp_err_o, q[0].err);
      end
      if (pa_v) begin
        chk("csb_act", sram_csb0_o, 0);
        chk("web_act", sram_web0_o, !pa_we);
        chk("wmask_act", sram_wmask0_o, pa_mask);
        chk("addr_act", sram_addr0_o, pa_addr);
        chk("din_act", sram_din0_o, pa_din);
      end else begin
        chk("csb_idle", sram_csb0_o, 1);
        chk("web_idle", sram_web0_o, 1);
        chk("wmask_idle", sram_wmask0_o, 0);
        chk("addr_hold", sram_addr0_o, last_addr);
        chk("din_hold", sram_din0_o, last_din);
      end
      pa_v = 1'b0;
      if (ev && rsp_ready_i) begin
        got.push_back('{q[0].data, q[0].err, q[0].acc, n});
        void'(q.pop_front());
      end
      if (req_valid_i && mrdy) begin
        e   = |req_addr_i[31:12];
        nop = req_we_i && (req_be_i == 4'h0);
        wa  = req_addr_i[11:2];
        d   = '0;
        if (!e && !req_we_i) d = mmem[wa];
        if (!e && req_we_i) begin
          m = mmem[wa];
          for (int b = 0; b < 4; b++)
            if (req_be_i[b]) m[8*b +: 8] = req_wdata_i[8*b +: 8];
          mmem[wa] = m;
        end
        q.push_back('{d, e, n + 1});
        if (!e && !nop) begin
          pa_v      = 1'b1;
          pa_we     = req_we_i;
          pa_mask   = req_we_i ? req_be_i : 4'h0;
          pa_addr   = wa;
          pa_din    = req_wdata_i;
          last_addr = wa;
          last_din  = req_wdata_i;
        end
      end
    end
    n++;
  end

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    int k;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_be_i    = be;
    req_wdata_i = d;
    k = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      k++;
      waits++;
      if (k > 50) begin
        tests++;
        fails++;
        $display("FAIL issue_timeout: got ready 0 expected 1 for 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int wa, input logic [31:0] d);
    sram_mem[wa] = d;
    mmem[wa] = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 1);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
    chk({tag, "_rsp_err"}, rsp_err_o, 0);
    chk({tag, "_csb"}, sram_csb0_o, 1);
    chk({tag, "_web"}, sram_web0_o, 1);
    chk({tag, "_wmask"}, sram_wmask0_o, 0);
    chk({tag, "_addr"}, sram_addr0_o, 0);
    chk({tag, "_din"}, sram_din0_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_be_i    = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 1024; i++) preload(i, 32'h0);
    for (int i = 0; i < 8; i++) preload(32'h40 + i, 32'hC0DE_0000 + i);
    #12;
    chk_reset_vals("rst0");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // write then read same word on the next cycle
    got.delete();
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    drain();
    chk("t1_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t1_wr_lat", got[0].cyc - got[0].acc, 2);
      chk("t1_wr_data", got[0].data, 32'h0);
      chk("t1_wr_err", got[0].err, 0);
      chk("t1_rd_data", got[1].data, 32'hDEADBEEF);
      chk("t1_rd_cyc", got[1].cyc - got[0].acc, 3);
    end

    // zero byte-enable write is acked but leaves memory untouched
    got.delete();
    issue(1'b1, 32'h10, 4'h0, 32'h12345678);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    drain();
    chk("t1b_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t1b_err", got[0].err, 0);
      chk("t1b_rd", got[1].data, 32'hDEADBEEF);
    end

    // byte-masked write
    got.delete();
    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20, 4'h5, 32'hAABBCCDD);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    drain();
    chk("t2_count", got.size(), 3);
    if (got.size() == 3) chk("t2_rd", got[2].data, 32'h11BB33DD);

    // eight back-to-back reads
    got.delete();
    waits = 0;
    for (int i = 0; i < 8; i++) issue(1'b0, 32'h100 + 4 * i, 4'h0, 32'h0);
    chk("t3_no_stall", waits, 0);
    drain();
    chk("t3_count", got.size(), 8);
    if (got.size() == 8) begin
      chk("t3_first_lat", got[0].cyc - got[0].acc, 2);
      for (int i = 0; i < 8; i++) begin
        chk("t3_data", got[i].data, 32'hC0DE_0000 + i);
        chk("t3_cyc", got[i].cyc - got[0].cyc, i);
      end
    end

    // backpressure: four credits then stall
    got.delete();
    rsp_ready_i = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 32'h100 + 4 * nacc;
      @(negedge clk);
      if (req_ready_o) nacc++;
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    chk("t4_accepts", nacc, 4);
    chk("t4_ready_low", req_ready_o, 0);
    chk("t4_head_valid", rsp_valid_o, 1);
    chk("t4_head_data", rsp_rdata_o, 32'hC0DE_0000);
    rsp_ready_i = 1'b1;
    issue(1'b0, 32'h110, 4'h0, 32'h0);
    issue(1'b0, 32'h114, 4'h0, 32'h0);
    drain();
    chk("t4_count", got.size(), 6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk("t4_data", got[i].data, 32'hC0DE_0000 + i);

    // out-of-range read sits in order between two good reads
    got.delete();
    issue(1'b0, 32'h100, 4'h0, 32'h0);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    issue(1'b0, 32'h104, 4'h0, 32'h0);
    drain();
    chk("t5_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t5_before", got[0].data, 32'hC0DE_0000);
      chk("t5_err", got[1].err, 1);
      chk("t5_err_data", got[1].data, 32'h0);
      chk("t5_after", got[2].data, 32'hC0DE_0001);
      chk("t5_after_err", got[2].err, 0);
    end

    // asynchronous reset with three requests in flight
    got.delete();
    issue(1'b0, 32'h108, 4'h0, 32'h0);
    issue(1'b0, 32'h10C, 4'h0, 32'h0);
    issue(1'b0, 32'h110, 4'h0, 32'h0);
    #1;
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("rst1");
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_stale", got.size(), 0);
    issue(1'b0, 32'h114, 4'h0, 32'h0);
    drain();
    chk("t6_count", got.size(), 1);
    if (got.size() == 1) begin
      chk("t6_data", got[0].data, 32'hC0DE_0005);
      chk("t6_lat", got[0].cyc - got[0].acc, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
